regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb_pkg.sv | 30 +++
 rtl/regfile_wr_arb_rr_pick2.sv | 46 ++++
 rtl/regfile_wr_arb.sv | 108 ++++++++++
 tb/tb_regfile_wr_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wr_arb_pkg.sv
// Shared widths and preference-state type for the
// register-file write arbiter.
package regfile_wr_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } pref_e;

  // The winner of a grant yields preference to the other side.
  function automatic pref_e pref_after(
    input pref_e cur,
    input logic  a_gnt,
    input logic  b_gnt
  );
    pref_e nxt;
    nxt = cur;
    if (a_gnt) begin
      nxt = PREF_B;
    end else if (b_gnt) begin
      nxt = PREF_A;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_wr_arb_rr_pick2.sv
// Two-way grant picker: a lone requester always wins,
// a tie is broken by the preference state.
module rr_pick2
  import regfile_wr_arb_pkg::*;
(
  input  logic  a_valid,
  input  logic  b_valid,
  input  logic  block,
  input  pref_e pref,
  output logic  a_gnt,
  output logic  b_gnt
);

  logic a_only;
  logic b_only;
  logic both;

  always_comb begin
    a_only = a_valid && !b_valid;
    b_only = b_valid && !a_valid;
    both   = a_valid && b_valid;
  end

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!block) begin
      unique case (1'b1)
        a_only: a_gnt = 1'b1;
        b_only: b_gnt = 1'b1;
        both: begin
          if (pref == PREF_A) begin
            a_gnt = 1'b1;
          end else begin
            b_gnt = 1'b1;
          end
        end
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates writeback (A) and multi-cycle unit (B) writes onto
// the single register-file write port, one write per cycle.
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DATA_W = regfile_wr_arb_pkg::DATA_W,
  parameter int ADDR_W = regfile_wr_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [CNT_W-1:0]  wr_count
);

  pref_e             pref_q;
  pref_e             pref_d;
  logic              wr_en_q;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] wr_data_d;
  logic              wr_src_q;
  logic              wr_src_d;
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;

  logic block;
  logic a_gnt;
  logic b_gnt;
  logic a_hs;
  logic b_hs;

  // Reset masks the readys combinationally so nothing handshakes
  // while the output registers are being held clear.
  assign block = stall | rst;

  rr_pick2 u_pick (
    .a_valid (a_valid),
    .b_valid (b_valid),
    .block   (block),
    .pref    (pref_q),
    .a_gnt   (a_gnt),
    .b_gnt   (b_gnt)
  );

  always_comb begin
    a_hs = a_gnt && a_valid;
    b_hs = b_gnt && b_valid;
  end

  always_comb begin
    pref_d     = pref_after(pref_q, a_hs, b_hs);
    wr_en_d    = a_hs | b_hs;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_src_d   = wr_src_q;
    wr_count_d = wr_count_q + CNT_W'(wr_en_q);
    if (a_hs) begin
      wr_addr_d = a_addr;
      wr_data_d = a_data;
      wr_src_d  = 1'b0;
    end else if (b_hs) begin
      wr_addr_d = b_addr;
      wr_data_d = b_data;
      wr_src_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pref_q     <= PREF_A;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_src_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      pref_q     <= pref_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_src_q   <= wr_src_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign a_ready  = a_gnt;
  assign b_ready  = b_gnt;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_src   = wr_src_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed plus random bench for regfile_wr_arb against an
// alternating-priority write-port reference model.
module tb_regfile_wr_arb;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        a_valid;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [2:0]  b_addr;
  logic [15:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_src;
  logic [7:0]  wr_count;

  int nasserts;
  int nfail;

  // reference model state
  bit          last_was_a;
  bit          exp_en;
  bit [2:0]    exp_addr;
  bit [15:0]   exp_data;
  bit          exp_src;
  int          writes_done;
  bit [15:0]   regs_m [8];
  logic [15:0] regs_dut [8];

  regfile_wr_arb dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_src   (wr_src),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    nasserts++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    last_was_a  = 1'b0;
    exp_en      = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
    exp_src     = 1'b0;
    writes_done = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, {31'd0, exp_en});
    chk({tag, "_wr_addr"}, {29'd0, wr_addr}, {29'd0, exp_addr});
    chk({tag, "_wr_data"}, {16'd0, wr_data}, {16'd0, exp_data});
    chk({tag, "_wr_src"}, {31'd0, wr_src}, {31'd0, exp_src});
    chk({tag, "_wr_count"}, {24'd0, wr_count},
        32'(writes_done % 256));
  endtask

  // One clock: drive at posedge+1, check readys, then check the
  // registered outputs at the following posedge+1.
  task automatic cycle(input string tag,
                       input bit av, input bit [2:0] aa,
                       input bit [15:0] ad,
                       input bit bv, input bit [2:0] ba,
                       input bit [15:0] bd, input bit st);
    bit ga;
    bit gb;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    stall = st;
    #1;
    // tie goes to whoever did not win the previous grant
    ga = !st && av && (!bv || !last_was_a);
    gb = !st && bv && (!av || last_was_a);
    chk({tag, "_a_ready"}, {31'd0, a_ready}, {31'd0, ga});
    chk({tag, "_b_ready"}, {31'd0, b_ready}, {31'd0, gb});
    @(posedge clk);
    #1;
    if (exp_en) writes_done++;
    exp_en = ga || gb;
    if (ga) begin
      exp_addr = aa; exp_data = ad; exp_src = 1'b0;
      last_was_a = 1'b1;
      regs_m[aa] = ad;
    end else if (gb) begin
      exp_addr = ba; exp_data = bd; exp_src = 1'b1;
      last_was_a = 1'b0;
      regs_m[ba] = bd;
    end
    chk_outputs(tag);
    if (wr_en === 1'b1) regs_dut[wr_addr] = wr_data;
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1; stall = 1'b0;
    #1;
    model_clear();
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk_outputs("rst");
    @(posedge clk);
    #1;
    chk_outputs("rst_edge");
    rst = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    nasserts = 0;
    nfail = 0;
    rst = 1'b1;
    stall = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    for (int i = 0; i < 8; i++) begin
      regs_m[i] = '0;
      regs_dut[i] = '0;
    end
    model_clear();

    do_reset();
    cycle("beef", 1, 3, 16'hBEEF, 0, 0, 0, 0);
    chk("beef_data", {16'd0, wr_data}, 32'h0000BEEF);
    idle("beef_idle");

    do_reset();
    for (int i = 0; i < 4; i++)
      cycle("alt", 1, 1, 16'(16'h100 + i), 1, 2, 16'(16'h200 + i), 0);
    idle("alt_idle");
    chk("alt_count4", {24'd0, wr_count}, 32'd4);

    cycle("pre_stall", 1, 1, 16'h11, 1, 2, 16'h22, 0);
    for (int i = 0; i < 3; i++)
      cycle("stall", 1, 1, 16'h33, 1, 2, 16'h44, 1);
    cycle("post_stall", 1, 1, 16'h55, 1, 2, 16'h66, 0);
    chk("post_stall_src_b", {31'd0, wr_src}, 32'd1);

    do_reset();
    cycle("to_prefb", 1, 0, 16'h7, 0, 0, 0, 0);
    cycle("same5_1", 1, 5, 16'h0001, 1, 5, 16'h0002, 0);
    chk("same5_first_b", {31'd0, wr_src}, 32'd1);
    cycle("same5_2", 1, 5, 16'h0001, 0, 5, 16'h0002, 0);
    idle("same5_idle");
    chk("same5_final", {16'd0, regs_dut[5]}, {16'd0, regs_m[5]});
    chk("same5_value", {16'd0, regs_dut[5]}, 32'h0001);

    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom), 3'($urandom), 16'($urandom),
            1'($urandom), 3'($urandom), 16'($urandom),
            ($urandom_range(0, 4) == 0));
    end
    idle("rand_idle");
    for (int i = 0; i < 8; i++)
      chk("rand_regs", {16'd0, regs_dut[i]}, {16'd0, regs_m[i]});

    do_reset();
    for (int i = 0; i < 256; i++)
      cycle("wrap", 1, 3'(i), 16'(i), 0, 0, 0, 0);
    idle("wrap_idle");
    chk("wrap_zero", {24'd0, wr_count}, 32'd0);

    cycle("arst_grant", 1, 6, 16'hCAFE, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk_outputs("arst_now");
    chk("arst_a_ready", {31'd0, a_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk_outputs("arst_next");
    rst = 1'b0;
    a_valid = 1'b0;
    idle("arst_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasserts, nfail);
    $finish;
  end

endmodule
